// File: rtl/seven_segment_scan_decoder_if.sv
// Frame-side handshake of the scanned 7-segment decoder: packed BCD frame,
// error flag, overrun pulse and the consumer's ready.
interface seven_segment_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic                    bcd_valid;
    logic                    bcd_ready;
    logic                    err_out;
    logic                    overrun;

    // A frame transfers on a rising edge where bcd_valid && bcd_ready; while
    // bcd_valid is high and not yet accepted, bcd_out and err_out do not change.
    modport master (output bcd_out, bcd_valid, err_out, overrun, input bcd_ready);
    modport slave  (input bcd_out, bcd_valid, err_out, overrun, output bcd_ready);
endinterface

// File: rtl/seven_segment_scan_decoder.sv
// Recovers packed BCD frames from a scanned 7-segment bus (segments + one-hot select).
// Define SEG_ACTIVE_LOW_EN for common-anode panels: both input buses are inverted first.
module seven_segment_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [6:0]                   segment,
    input  logic [NUM_DIGITS-1:0]        dig_sel,
    seven_segment_scan_decoder_if.master frame_if,
    output logic                         dbg_state
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   sel_in;
    logic [6:0]              s1_seg;
    logic [NUM_DIGITS-1:0]   s1_sel;
    logic [CW-1:0]           cnt;
    logic                    sel_onehot;
    logic                    capture;
    logic                    complete;
    logic [3:0]              dec_nib;
    logic                    dec_err;
    logic [NUM_DIGITS-1:0]   mask, mask_nx;
    logic [4*NUM_DIGITS-1:0] frame_bcd, frame_bcd_nx;
    logic [NUM_DIGITS-1:0]   frame_err, frame_err_nx;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic                    valid_q;
    logic                    err_q;
    logic                    ovr_q;

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_in = ~segment;
    assign sel_in = ~dig_sel;
`else
    assign seg_in = segment;
    assign sel_in = dig_sel;
`endif

    // cnt tracks how many cycles s1 has already held its current value; it saturates
    // one above the capture value so a long dwell matches CNT_CAP exactly once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_seg <= '0;
            s1_sel <= '0;
            cnt    <= '0;
        end else begin
            s1_seg <= seg_in;
            s1_sel <= sel_in;
            if ({seg_in, sel_in} != {s1_seg, s1_sel}) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign sel_onehot = (s1_sel != '0) && ((s1_sel & (s1_sel - NUM_DIGITS'(1))) == '0);
    assign capture    = (cnt == CNT_CAP) && sel_onehot;
    assign complete   = &mask;

    always_comb begin
        dec_nib = 4'hE;
        dec_err = 1'b1;
        case (s1_seg)
            7'h7E: begin dec_nib = 4'd0; dec_err = 1'b0; end
            7'h30: begin dec_nib = 4'd1; dec_err = 1'b0; end
            7'h6D: begin dec_nib = 4'd2; dec_err = 1'b0; end
            7'h79: begin dec_nib = 4'd3; dec_err = 1'b0; end
            7'h33: begin dec_nib = 4'd4; dec_err = 1'b0; end
            7'h5B: begin dec_nib = 4'd5; dec_err = 1'b0; end
            7'h5F: begin dec_nib = 4'd6; dec_err = 1'b0; end
            7'h70: begin dec_nib = 4'd7; dec_err = 1'b0; end
            7'h7F: begin dec_nib = 4'd8; dec_err = 1'b0; end
            7'h7B: begin dec_nib = 4'd9; dec_err = 1'b0; end
            7'h00: begin dec_nib = 4'hF; dec_err = 1'b0; end
            default: ;
        endcase
    end

    // A full mask is seen for exactly one cycle: it clears on the edge that loads the output.
    always_comb begin
        state_nx     = state;
        mask_nx      = mask;
        frame_bcd_nx = frame_bcd;
        frame_err_nx = frame_err;
        if (complete) begin
            mask_nx = '0;
        end
        if (capture) begin
            mask_nx = mask_nx | s1_sel;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s1_sel[i]) begin
                    frame_bcd_nx[4*i +: 4] = dec_nib;
                    frame_err_nx[i]        = dec_err;
                end
            end
        end
        case (state)
            IDLE:    if (capture) state_nx = COLLECT;
            COLLECT: state_nx = COLLECT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            frame_bcd <= '0;
            frame_err <= '0;
        end else begin
            state     <= state_nx;
            mask      <= mask_nx;
            frame_bcd <= frame_bcd_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || frame_if.bcd_ready) begin
                    bcd_q   <= frame_bcd;
                    err_q   <= |frame_err;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && frame_if.bcd_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign frame_if.bcd_out   = bcd_q;
    assign frame_if.bcd_valid = valid_q;
    assign frame_if.err_out   = err_q;
    assign frame_if.overrun   = ovr_q;
    assign dbg_state          = state;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed scans plus random scans, with a
// frame-level reference model feeding a scoreboard queue checked by a monitor.
module tb_seven_segment_scan_decoder;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int W  = 4*N + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   segment;
    logic [N-1:0] dig_sel;
    logic         dbg_state;

    seven_segment_scan_decoder_if #(.NUM_DIGITS(N)) fif ();

    seven_segment_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .segment   (segment),
        .dig_sel   (dig_sel),
        .frame_if  (fif),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int           exp_ovr = 0;
    bit           exp_drop = 0;

    logic [6:0]   seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    logic [N-1:0] bad_sel [5]  = '{4'b0000, 4'b0110, 4'b1010, 4'b1111, 4'b0011};

    // model: which slots hold a digit for the frame being assembled
    logic [3:0]   m_nib  [N];
    bit           m_err  [N];
    bit           m_have [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return {1'b0, 4'hF};
        for (int d = 0; d < 10; d++) begin
            if (seg_tab[d] == p) return {1'b0, 4'(d)};
        end
        return {1'b1, 4'hE};
    endfunction

    task automatic model_dwell(input logic [6:0] seg, input logic [N-1:0] sel, input int d);
        logic [4:0]   dec;
        logic [W-1:0] f;
        bit           full;
        if (d < SC || $countones(sel) != 1) return;
        for (int k = 0; k < N; k++) begin
            if (sel[k]) begin
                dec       = ref_decode(seg);
                m_err[k]  = dec[4];
                m_nib[k]  = dec[3:0];
                m_have[k] = 1'b1;
            end
        end
        full = 1'b1;
        for (int k = 0; k < N; k++) full = full & m_have[k];
        if (full) begin
            f = '0;
            for (int k = 0; k < N; k++) begin
                f[4*k +: 4] = m_nib[k];
                f[W-1]      = f[W-1] | m_err[k];
                m_have[k]   = 1'b0;
            end
            if (exp_drop) exp_ovr++;
            else exp_q.push_back(f);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [6:0] seg, input logic [N-1:0] sel);
`ifdef SEG_ACTIVE_LOW_EN
        segment = ~seg;
        dig_sel = ~sel;
`else
        segment = seg;
        dig_sel = sel;
`endif
    endtask

    task automatic drive(input logic [6:0] seg, input logic [N-1:0] sel, input int d);
        set_pins(seg, sel);
        model_dwell(seg, sel, d);
        repeat (d) tick();
    endtask

    // pats: digit i pattern in pats[7*i +: 7]; digit short_dig dwells short_d instead of d
    task automatic scan(input logic [7*N-1:0] pats, input int d, input int short_dig, input int short_d);
        for (int i = 0; i < N; i++) begin
            drive(pats[7*i +: 7], N'(1) << i, (i == short_dig) ? short_d : d);
        end
    endtask

    task automatic do_reset();
        repeat (4) tick();
        set_pins(7'h00, '0);
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(fif.bcd_valid), 0);
        check("rst_bcd", 32'(fif.bcd_out), 0);
        check("rst_err", 32'(fif.err_out), 0);
        check("rst_ovr", 32'(fif.overrun), 0);
        check("rst_state", 32'(dbg_state), 0);
        for (int k = 0; k < N; k++) m_have[k] = 1'b0;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fif.bcd_valid && fif.bcd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %0h expected no frame",
                             {fif.err_out, fif.bcd_out});
                end else begin
                    e = exp_q.pop_front();
                    check("frame", 32'({fif.err_out, fif.bcd_out}), 32'(e));
                end
            end
            if (fif.overrun) begin
                checks++;
                if (exp_ovr == 0) begin
                    errors++;
                    $display("FAIL overrun_unexpected: got 1 expected 0");
                end else begin
                    exp_ovr--;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            m_have[k] = 1'b0;
            m_nib[k]  = 4'h0;
            m_err[k]  = 1'b0;
        end
        fif.bcd_ready = 1'b1;
        set_pins(7'h00, '0);
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_valid", 32'(fif.bcd_valid), 0);
        check("reset_bcd", 32'(fif.bcd_out), 0);
        check("reset_state", 32'(dbg_state), 0);
        rst_n = 1'b1;

        // basic scan, with latency and single-pulse checks on the last digit
        drive(7'h79, 4'b0001, 6);
        drive(7'h5B, 4'b0010, 6);
        drive(7'h30, 4'b0100, 6);
        drive(7'h7E, 4'b1000, 5);
        check("latency_early", 32'(fif.bcd_valid), 0);
        tick();
        check("latency_valid", 32'(fif.bcd_valid), 1);
        check("t1_bcd", 32'(fif.bcd_out), 32'h0153);
        check("t1_err", 32'(fif.err_out), 0);
        check("t1_state", 32'(dbg_state), 1);
        tick();
        check("t1_one_pulse", 32'(fif.bcd_valid), 0);

        // short dwell on digit 2, then a full scan supplies it
        scan({7'h7E, 7'h30, 7'h5B, 7'h79}, 6, 2, 3);
        scan({7'h33, 7'h5F, 7'h70, 7'h7F}, 6, -1, 0);

        // illegal and blank patterns
        scan({7'h00, 7'h30, 7'h01, 7'h79}, 6, -1, 0);
        scan({7'h00, 7'h30, 7'h5B, 7'h79}, 6, -1, 0);

        // zero and multi-hot select never capture
        drive(7'h6D, 4'b0001, 6);
        drive(7'h7B, 4'b0010, 6);
        drive(7'h30, 4'b0110, 10);
        drive(7'h30, 4'b0000, 10);
        drive(7'h70, 4'b0100, 6);
        drive(7'h5F, 4'b1000, 6);

        // reset after two captures discards the partial frame
        do_reset();
        drive(7'h79, 4'b0001, 6);
        drive(7'h5B, 4'b0010, 6);
        do_reset();
        scan({7'h7B, 7'h7F, 7'h33, 7'h6D}, 6, -1, 0);

        // consumer stalled across two scans, released on the third completion cycle
        do_reset();
        fif.bcd_ready = 1'b0;
        scan({7'h30, 7'h6D, 7'h79, 7'h33}, 6, -1, 0);
        exp_drop = 1'b1;
        scan({7'h5B, 7'h5F, 7'h70, 7'h7F}, 6, -1, 0);
        exp_drop = 1'b0;
        drive(7'h7B, 4'b0001, 6);
        drive(7'h7E, 4'b0010, 6);
        drive(7'h30, 4'b0100, 6);
        drive(7'h6D, 4'b1000, 5);
        fif.bcd_ready = 1'b1;
        tick();
        tick();
        check("t4_overruns", 32'(exp_ovr), 0);

        // random scans
        for (int s = 0; s < 25; s++) begin
            for (int i = 0; i < N; i++) begin
                int         r;
                logic [6:0] p;
                if ($urandom_range(0, 5) == 0) begin
                    drive(7'($urandom), bad_sel[$urandom_range(0, 4)], $urandom_range(1, 6));
                end
                r = $urandom_range(0, 11);
                p = (r < 10) ? seg_tab[r] : ((r == 10) ? 7'h00 : 7'($urandom));
                drive(p, N'(1) << i, $urandom_range(2, 8));
            end
        end

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
        check("queue_drained", 32'(exp_q.size()), 0);
        check("overruns_seen", 32'(exp_ovr), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
